// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller: FSM encoding,
// BCD digit limits, the displayed-time payload and the minutes-limit check.
package stopwatch_pkg;

    localparam int unsigned DIGIT_W = 4;

    localparam logic [DIGIT_W-1:0] BCD_LIM9 = 4'd9;
    localparam logic [DIGIT_W-1:0] BCD_LIM5 = 4'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2,
        ST_LAP  = 2'd3
    } state_e;

    typedef struct packed {
        logic [DIGIT_W-1:0] m10;
        logic [DIGIT_W-1:0] m1;
        logic [DIGIT_W-1:0] s10;
        logic [DIGIT_W-1:0] s1;
        logic [DIGIT_W-1:0] c10;
        logic [DIGIT_W-1:0] c1;
    } time_t;

    function automatic bit min_limit_ok(input int unsigned lim);
        return (lim >= 1) && (lim <= 99);
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Tick/button inputs and display/status outputs of the stopwatch controller.
interface stopwatch_ctrl_if;
    import stopwatch_pkg::*;

    logic               EN10MS;
    logic               BTN_SS;
    logic               BTN_CLR;
    logic [DIGIT_W-1:0] DISP_M10;
    logic [DIGIT_W-1:0] DISP_M1;
    logic [DIGIT_W-1:0] DISP_S10;
    logic [DIGIT_W-1:0] DISP_S1;
    logic [DIGIT_W-1:0] DISP_C10;
    logic [DIGIT_W-1:0] DISP_C1;
    logic               RUNNING;
    logic               LAPMODE;
    logic               OVF;

    modport master (
        output EN10MS, BTN_SS, BTN_CLR,
        input  DISP_M10, DISP_M1, DISP_S10, DISP_S1, DISP_C10, DISP_C1,
        input  RUNNING, LAPMODE, OVF
    );

    modport slave (
        input  EN10MS, BTN_SS, BTN_CLR,
        output DISP_M10, DISP_M1, DISP_S10, DISP_S1, DISP_C10, DISP_C1,
        output RUNNING, LAPMODE, OVF
    );

endinterface

// File: rtl/bcd_digit.sv
// Mod-(limit+1) BCD digit counter; CLR beats INC, CARRY flags the rollover tick.
module bcd_digit
    import stopwatch_pkg::*;
(
    input  logic               CLK,
    input  logic               RST,
    input  logic               CLR,
    input  logic               INC,
    input  logic [DIGIT_W-1:0] limit,
    output logic [DIGIT_W-1:0] Q,
    output logic               CARRY
);

    logic [DIGIT_W-1:0] q_q;
    logic [DIGIT_W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (CLR) begin
            q_d = '0;
        end else if (INC) begin
            q_d = (q_q == limit) ? '0 : q_q + DIGIT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) q_q <= '0;
        else     q_q <= q_d;
    end

    assign Q     = q_q;
    assign CARRY = INC & (q_q == limit);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: start/stop/lap/clear FSM driven by button presses,
// MM:SS.cc BCD count advanced by the 100 Hz tick, lap freeze and wrap flag.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned MIN_LIMIT = 59
) (
    input  logic             CLK,
    input  logic             RST,
    stopwatch_ctrl_if.slave  bus
);

    if (!min_limit_ok(MIN_LIMIT)) begin : g_bad_limit
        $error("stopwatch_ctrl: MIN_LIMIT must be within 1..99");
    end

    localparam logic [DIGIT_W-1:0] MIN_M10 = DIGIT_W'(MIN_LIMIT / 10);
    localparam logic [DIGIT_W-1:0] MIN_M1  = DIGIT_W'(MIN_LIMIT % 10);

    state_e state_q, state_d;
    time_t  lap_q, lap_d;
    logic   ovf_q, ovf_d;
    logic   btn_ss_q, btn_clr_q;
    logic   armed_q;

    logic   ss_press, clr_press;
    logic   count_en, zero_c, wrap_c, digit_clr;
    time_t  cnt;
    time_t  disp_c;

    logic [DIGIT_W-1:0] m10_q, m1_q, s10_q, s1_q, c10_q, c1_q;
    logic               m10_cy, m1_cy, s10_cy, s1_cy, c10_cy, c1_cy;

    // armed_q masks the first post-reset edge so a button held through reset is not a press
    assign ss_press  = bus.BTN_SS  & ~btn_ss_q  & armed_q;
    assign clr_press = bus.BTN_CLR & ~btn_clr_q & armed_q;

    assign count_en  = bus.EN10MS & ((state_q == ST_RUN) || (state_q == ST_LAP));
    assign zero_c    = clr_press & (state_q == ST_STOP);
    assign wrap_c    = (s10_cy & (m10_q == MIN_M10) & (m1_q == MIN_M1)) | m10_cy;
    assign digit_clr = zero_c | wrap_c;
    assign cnt       = {m10_q, m1_q, s10_q, s1_q, c10_q, c1_q};

    bcd_digit u_c1  (.CLK(CLK), .RST(RST), .CLR(digit_clr), .INC(count_en), .limit(BCD_LIM9), .Q(c1_q),  .CARRY(c1_cy));
    bcd_digit u_c10 (.CLK(CLK), .RST(RST), .CLR(digit_clr), .INC(c1_cy),    .limit(BCD_LIM9), .Q(c10_q), .CARRY(c10_cy));
    bcd_digit u_s1  (.CLK(CLK), .RST(RST), .CLR(digit_clr), .INC(c10_cy),   .limit(BCD_LIM9), .Q(s1_q),  .CARRY(s1_cy));
    bcd_digit u_s10 (.CLK(CLK), .RST(RST), .CLR(digit_clr), .INC(s1_cy),    .limit(BCD_LIM5), .Q(s10_q), .CARRY(s10_cy));
    bcd_digit u_m1  (.CLK(CLK), .RST(RST), .CLR(digit_clr), .INC(s10_cy),   .limit(BCD_LIM9), .Q(m1_q),  .CARRY(m1_cy));
    bcd_digit u_m10 (.CLK(CLK), .RST(RST), .CLR(digit_clr), .INC(m1_cy),    .limit(BCD_LIM9), .Q(m10_q), .CARRY(m10_cy));

    // State and control registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            lap_q     <= '0;
            ovf_q     <= 1'b0;
            btn_ss_q  <= 1'b0;
            btn_clr_q <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            lap_q     <= lap_d;
            ovf_q     <= ovf_d;
            btn_ss_q  <= bus.BTN_SS;
            btn_clr_q <= bus.BTN_CLR;
            armed_q   <= 1'b1;
        end
    end

    // Next state; a CLR press masks a simultaneous SS press
    always_comb begin
        state_d = state_q;
        lap_d   = lap_q;
        ovf_d   = ovf_q;
        if (clr_press) begin
            case (state_q)
                ST_RUN:  begin state_d = ST_LAP; lap_d = cnt; end
                ST_LAP:  state_d = ST_RUN;
                ST_STOP: state_d = ST_IDLE;
                default: state_d = state_q;
            endcase
        end else if (ss_press) begin
            case (state_q)
                ST_IDLE: state_d = ST_RUN;
                ST_RUN:  state_d = ST_STOP;
                ST_STOP: state_d = ST_RUN;
                default: state_d = ST_STOP;
            endcase
        end
        if (zero_c)      ovf_d = 1'b0;
        else if (wrap_c) ovf_d = 1'b1;
    end

    // Outputs decoded from registers only
    always_comb begin
        disp_c       = (state_q == ST_LAP) ? lap_q : cnt;
        bus.DISP_M10 = disp_c.m10;
        bus.DISP_M1  = disp_c.m1;
        bus.DISP_S10 = disp_c.s10;
        bus.DISP_S1  = disp_c.s1;
        bus.DISP_C10 = disp_c.c10;
        bus.DISP_C1  = disp_c.c1;
        bus.RUNNING  = (state_q == ST_RUN) || (state_q == ST_LAP);
        bus.LAPMODE  = (state_q == ST_LAP);
        bus.OVF      = ovf_q;
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl (MIN_LIMIT=1 so the wrap is reachable quickly).
module tb_stopwatch_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    stopwatch_ctrl_if sw_if ();

    stopwatch_ctrl #(.MIN_LIMIT(1)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (sw_if)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] dv();
        return {sw_if.DISP_M10, sw_if.DISP_M1, sw_if.DISP_S10,
                sw_if.DISP_S1, sw_if.DISP_C10, sw_if.DISP_C1};
    endfunction

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic ticks(input int n);
        repeat (n) begin sw_if.EN10MS = 1'b1; @(posedge clk); #1; end
        sw_if.EN10MS = 1'b0;
    endtask

    task automatic press_ss();
        sw_if.BTN_SS = 1'b1; step(1);
        sw_if.BTN_SS = 1'b0; step(1);
    endtask

    task automatic press_clr();
        sw_if.BTN_CLR = 1'b1; step(1);
        sw_if.BTN_CLR = 1'b0; step(1);
    endtask

    task automatic test_reset();
        rst = 1'b1; sw_if.EN10MS = 1'b0; sw_if.BTN_SS = 1'b0; sw_if.BTN_CLR = 1'b0;
        step(2);
        rst = 1'b0;
        step(2);
        checks++; if (dv() !== 24'h000000) begin errors++; $display("FAIL reset_disp: got %h want 000000", dv()); end
        checks++; if (sw_if.RUNNING !== 1'b0) begin errors++; $display("FAIL reset_running: got %b want 0", sw_if.RUNNING); end
        checks++; if (sw_if.LAPMODE !== 1'b0) begin errors++; $display("FAIL reset_lapmode: got %b want 0", sw_if.LAPMODE); end
        checks++; if (sw_if.OVF !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", sw_if.OVF); end
    endtask

    task automatic test_run_stop();
        sw_if.BTN_SS = 1'b1; step(1);
        checks++; if (sw_if.RUNNING !== 1'b1) begin errors++; $display("FAIL start_latency: got %b want 1", sw_if.RUNNING); end
        sw_if.BTN_SS = 1'b0; step(1);
        ticks(150);
        checks++; if (dv() !== 24'h000150) begin errors++; $display("FAIL run_150: got %h want 000150", dv()); end
        press_ss();
        checks++; if (sw_if.RUNNING !== 1'b0) begin errors++; $display("FAIL stop_running: got %b want 0", sw_if.RUNNING); end
        ticks(20);
        checks++; if (dv() !== 24'h000150) begin errors++; $display("FAIL stop_frozen: got %h want 000150", dv()); end
    endtask

    task automatic test_clear();
        press_ss(); ticks(350); press_ss();
        checks++; if (dv() !== 24'h000500) begin errors++; $display("FAIL stop_500: got %h want 000500", dv()); end
        press_clr();
        checks++; if (dv() !== 24'h000000) begin errors++; $display("FAIL clear_disp: got %h want 000000", dv()); end
        checks++; if (sw_if.RUNNING !== 1'b0) begin errors++; $display("FAIL clear_running: got %b want 0", sw_if.RUNNING); end
        press_clr();
        checks++; if ({sw_if.RUNNING, sw_if.LAPMODE, dv()} !== 26'h0) begin errors++; $display("FAIL idle_clr_noop: got %h want 0", {sw_if.RUNNING, sw_if.LAPMODE, dv()}); end
        press_ss(); ticks(5); press_ss();
        checks++; if (dv() !== 24'h000005) begin errors++; $display("FAIL stop_005: got %h want 000005", dv()); end
        sw_if.BTN_SS = 1'b1; sw_if.BTN_CLR = 1'b1; step(1);
        sw_if.BTN_SS = 1'b0; sw_if.BTN_CLR = 1'b0; step(1);
        checks++; if ({sw_if.RUNNING, sw_if.LAPMODE, dv()} !== 26'h0) begin errors++; $display("FAIL ss_clr_to_idle: got %h want 0", {sw_if.RUNNING, sw_if.LAPMODE, dv()}); end
    endtask

    task automatic test_lap();
        press_ss(); ticks(42);
        checks++; if (dv() !== 24'h000042) begin errors++; $display("FAIL run_042: got %h want 000042", dv()); end
        press_clr();
        checks++; if ({sw_if.RUNNING, sw_if.LAPMODE} !== 2'b11) begin errors++; $display("FAIL lap_enter: got %b want 11", {sw_if.RUNNING, sw_if.LAPMODE}); end
        ticks(100);
        checks++; if (dv() !== 24'h000042) begin errors++; $display("FAIL lap_frozen: got %h want 000042", dv()); end
        press_clr();
        checks++; if (sw_if.LAPMODE !== 1'b0) begin errors++; $display("FAIL lap_exit: got %b want 0", sw_if.LAPMODE); end
        checks++; if (dv() !== 24'h000142) begin errors++; $display("FAIL lap_live: got %h want 000142", dv()); end
        // CLR with a coincident tick: lap holds the pre-increment value
        sw_if.BTN_CLR = 1'b1; sw_if.EN10MS = 1'b1; step(1);
        sw_if.BTN_CLR = 1'b0; sw_if.EN10MS = 1'b0;
        checks++; if (dv() !== 24'h000142) begin errors++; $display("FAIL lap_pre_inc: got %h want 000142", dv()); end
        step(1); ticks(1);
        press_ss();
        checks++; if ({sw_if.RUNNING, sw_if.LAPMODE} !== 2'b00) begin errors++; $display("FAIL lap_to_stop: got %b want 00", {sw_if.RUNNING, sw_if.LAPMODE}); end
        checks++; if (dv() !== 24'h000144) begin errors++; $display("FAIL lap_stop_live: got %h want 000144", dv()); end
    endtask

    task automatic test_coincident();
        press_clr(); press_ss(); ticks(9);
        checks++; if (dv() !== 24'h000009) begin errors++; $display("FAIL run_009: got %h want 000009", dv()); end
        sw_if.BTN_SS = 1'b1; sw_if.EN10MS = 1'b1; step(1);
        sw_if.BTN_SS = 1'b0; sw_if.EN10MS = 1'b0;
        checks++; if ({sw_if.RUNNING, dv()} !== {1'b0, 24'h000010}) begin errors++; $display("FAIL run_ss_tick: got %h want 0000010", {sw_if.RUNNING, dv()}); end
        step(1);
        sw_if.BTN_SS = 1'b1; sw_if.EN10MS = 1'b1; step(1);
        sw_if.BTN_SS = 1'b0; sw_if.EN10MS = 1'b0;
        checks++; if ({sw_if.RUNNING, dv()} !== {1'b1, 24'h000010}) begin errors++; $display("FAIL stop_ss_tick: got %h want 1000010", {sw_if.RUNNING, dv()}); end
        step(1); ticks(1);
        checks++; if (dv() !== 24'h000011) begin errors++; $display("FAIL first_tick: got %h want 000011", dv()); end
        press_ss();
        sw_if.BTN_CLR = 1'b1; sw_if.EN10MS = 1'b1; step(1);
        sw_if.BTN_CLR = 1'b0; sw_if.EN10MS = 1'b0; step(1);
        checks++; if ({sw_if.RUNNING, dv()} !== 25'h0) begin errors++; $display("FAIL stop_clr_tick: got %h want 0", {sw_if.RUNNING, dv()}); end
    endtask

    task automatic test_wrap();
        press_ss(); ticks(6000);
        checks++; if (dv() !== 24'h010000) begin errors++; $display("FAIL min_carry: got %h want 010000", dv()); end
        ticks(5999);
        checks++; if ({sw_if.OVF, dv()} !== {1'b0, 24'h015999}) begin errors++; $display("FAIL pre_wrap: got %h want 0015999", {sw_if.OVF, dv()}); end
        ticks(1);
        checks++; if ({sw_if.RUNNING, sw_if.OVF, dv()} !== {2'b11, 24'h000000}) begin errors++; $display("FAIL wrap: got %h want 3000000", {sw_if.RUNNING, sw_if.OVF, dv()}); end
        ticks(250);
        checks++; if ({sw_if.OVF, dv()} !== {1'b1, 24'h000250}) begin errors++; $display("FAIL ovf_hold_run: got %h want 1000250", {sw_if.OVF, dv()}); end
        press_ss();
        checks++; if (sw_if.OVF !== 1'b1) begin errors++; $display("FAIL ovf_hold_stop: got %b want 1", sw_if.OVF); end
        press_clr();
        checks++; if ({sw_if.OVF, dv()} !== 25'h0) begin errors++; $display("FAIL ovf_clear: got %h want 0", {sw_if.OVF, dv()}); end
    endtask

    task automatic test_reset_midrun();
        press_ss(); ticks(1234);
        checks++; if (dv() !== 24'h001234) begin errors++; $display("FAIL run_1234: got %h want 001234", dv()); end
        sw_if.BTN_SS = 1'b1; sw_if.EN10MS = 1'b1; rst = 1'b1; step(2);
        checks++; if ({sw_if.RUNNING, sw_if.LAPMODE, sw_if.OVF, dv()} !== 27'h0) begin errors++; $display("FAIL midrun_reset: got %h want 0", {sw_if.RUNNING, sw_if.LAPMODE, sw_if.OVF, dv()}); end
        rst = 1'b0; step(3);
        checks++; if ({sw_if.RUNNING, dv()} !== 25'h0) begin errors++; $display("FAIL held_no_start: got %h want 0", {sw_if.RUNNING, dv()}); end
        sw_if.BTN_SS = 1'b0; sw_if.EN10MS = 1'b0; step(1);
        press_ss(); ticks(3);
        checks++; if ({sw_if.RUNNING, dv()} !== {1'b1, 24'h000003}) begin errors++; $display("FAIL restart: got %h want 1000003", {sw_if.RUNNING, dv()}); end
    endtask

    initial begin
        test_reset();
        test_run_stop();
        test_clear();
        test_lap();
        test_coincident();
        test_wrap();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
